// File: rtl/perf_counter_unit_if.sv
// Readout stream port of the performance-counter block: one snapshot word per
// beat, valid/ready handshake, beat index and last-beat marker.
interface perf_counter_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  rdValid;
  logic                  rdReady;
  logic [DATA_WIDTH-1:0] rdData;
  logic [2:0]            rdIndex;
  logic                  rdLast;

  modport master (
    output rdValid,
    output rdData,
    output rdIndex,
    output rdLast,
    input  rdReady
  );

  modport slave (
    input  rdValid,
    input  rdData,
    input  rdIndex,
    input  rdLast,
    output rdReady
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Performance counters: accumulates per-cycle event increments into live
// counters and streams a coherent snapshot (counters, then overflow flags).
module perf_counter_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_EVENTS = 7,
  parameter int unsigned INC_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             countEnable,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0]  eventInc,
  input  logic                             clearReq,
  input  logic                             snapshotReq,
  output logic [NUM_EVENTS*DATA_WIDTH-1:0] perfCounter,
  output logic [NUM_EVENTS-1:0]            overflow,
  output logic                             busy,
  perf_counter_unit_if.master              rd
);

  // rdIndex is 3 bits wide, so NUM_EVENTS must not exceed 7.
  localparam logic [2:0] LAST_IDX = 3'(NUM_EVENTS);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] cnt_q      [NUM_EVENTS];
  logic [DATA_WIDTH-1:0] cnt_d      [NUM_EVENTS];
  logic [DATA_WIDTH:0]   sum        [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] shadow_q   [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] shadow_ovf_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [2:0]            rd_index_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  busy_q;
  logic [2:0]            next_idx;
  logic [DATA_WIDTH-1:0] next_data;

  // Clear has priority over the same cycle's increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + (DATA_WIDTH+1)'(eventInc[i*INC_WIDTH +: INC_WIDTH]);
      if (clearReq) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (countEnable) begin
        cnt_d[i] = sum[i][DATA_WIDTH-1:0];
        ovf_d[i] = ovf_q[i] | sum[i][DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_export
    assign perfCounter[(NUM_EVENTS-1-g)*DATA_WIDTH +: DATA_WIDTH] = cnt_q[g];
  end
  assign overflow = ovf_q;

  // Word for the beat after the current one; the final beat carries the flags.
  always_comb begin
    next_idx  = rd_index_q + 3'd1;
    next_data = DATA_WIDTH'(shadow_ovf_q);
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (next_idx == 3'(i)) begin
        next_data = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        shadow_q[i] <= '0;
      end
      shadow_ovf_q <= '0;
      rd_data_q    <= '0;
      rd_index_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snapshotReq) begin
            // Beat 0 is loaded straight from the live counters being captured.
            shadow_q     <= cnt_q;
            shadow_ovf_q <= ovf_q;
            rd_data_q    <= cnt_q[0];
            rd_index_q   <= '0;
            rd_last_q    <= 1'b0;
            rd_valid_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= STREAM;
          end
        end
        STREAM: begin
          if (rd.rdReady) begin
            if (rd_last_q) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              rd_index_q <= '0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              rd_index_q <= next_idx;
              rd_data_q  <= next_data;
              rd_last_q  <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd.rdValid = rd_valid_q;
  assign rd.rdData  = rd_data_q;
  assign rd.rdIndex = rd_index_q;
  assign rd.rdLast  = rd_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: reference model of the counters plus a queue of
// expected readout beats, checked as the stream is consumed.
module tb_perf_counter_unit;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic         countEnable;
  logic [13:0]  eventInc;
  logic         clearReq;
  logic         snapshotReq;
  logic [223:0] perfCounter;
  logic [6:0]   overflow;
  logic         busy;

  logic         en8;
  logic [13:0]  inc8;
  logic         clr8;
  logic         snap8;
  logic [55:0]  perf8;
  logic [6:0]   ovf8;
  logic         busy8;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_cnt [7];
  logic [6:0]  exp_ovf;
  logic        model_idle;
  logic        end_pending;
  int          beats_seen;
  beat_t       sb [$];

  perf_counter_unit_if #(.DATA_WIDTH(32)) rd_if ();
  perf_counter_unit_if #(.DATA_WIDTH(8))  rd8_if ();

  perf_counter_unit #(.DATA_WIDTH(32), .NUM_EVENTS(7), .INC_WIDTH(2)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .countEnable (countEnable),
    .eventInc    (eventInc),
    .clearReq    (clearReq),
    .snapshotReq (snapshotReq),
    .perfCounter (perfCounter),
    .overflow    (overflow),
    .busy        (busy),
    .rd          (rd_if)
  );

  // Narrow instance so counter wrap is reachable in a short run.
  perf_counter_unit #(.DATA_WIDTH(8), .NUM_EVENTS(7), .INC_WIDTH(2)) dut8 (
    .clk         (clk),
    .rstN        (rstN),
    .countEnable (en8),
    .eventInc    (inc8),
    .clearReq    (clr8),
    .snapshotReq (snap8),
    .perfCounter (perf8),
    .overflow    (ovf8),
    .busy        (busy8),
    .rd          (rd8_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] inc1(input int idx, input logic [1:0] v);
    return {12'b0, v} << (2 * idx);
  endfunction

  function automatic logic [223:0] exp_vec();
    logic [223:0] v;
    for (int i = 0; i < 7; i++) v[(6 - i) * 32 +: 32] = exp_cnt[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) exp_cnt[i] = '0;
    exp_ovf     = '0;
    model_idle  = 1'b1;
    end_pending = 1'b0;
    sb.delete();
  endtask

  // One clock: drive, check the presented beat at negedge, update the model at posedge.
  task automatic step(input logic en, input logic [13:0] inc, input logic clr,
                      input logic snap, input logic rdy);
    logic        idle_now;
    logic        exp_v;
    beat_t       b;
    logic [32:0] s;
    countEnable     = en;
    eventInc        = inc;
    clearReq        = clr;
    snapshotReq     = snap;
    rd_if.rdReady   = rdy;
    idle_now        = model_idle;
    @(negedge clk);
    exp_v = ~model_idle;
    checks++;
    if (rd_if.rdValid !== exp_v || busy !== exp_v) begin
      errors++;
      $display("FAIL stream_state: rdValid=%b busy=%b required %b", rd_if.rdValid, busy, exp_v);
    end
    if (rd_if.rdValid === 1'b1) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: idx=%0d data=%h with nothing expected", rd_if.rdIndex, rd_if.rdData);
      end else begin
        b = sb[0];
        checks++;
        if (rd_if.rdData !== b.data || rd_if.rdIndex !== b.idx || rd_if.rdLast !== b.last) begin
          errors++;
          $display("FAIL beat: got data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                   rd_if.rdData, rd_if.rdIndex, rd_if.rdLast, b.data, b.idx, b.last);
        end
        if (rdy) begin
          void'(sb.pop_front());
          beats_seen++;
          if (b.last) end_pending = 1'b1;
        end
      end
    end
    @(posedge clk);
    if (idle_now && snap) begin
      for (int i = 0; i < 7; i++) sb.push_back('{exp_cnt[i], 3'(i), 1'b0});
      sb.push_back('{32'(exp_ovf), 3'd7, 1'b1});
      model_idle = 1'b0;
    end
    if (end_pending) begin
      model_idle  = 1'b1;
      end_pending = 1'b0;
    end
    for (int i = 0; i < 7; i++) begin
      s = {1'b0, exp_cnt[i]} + 33'(inc[2 * i +: 2]);
      if (clr) begin
        exp_cnt[i] = '0;
        exp_ovf[i] = 1'b0;
      end else if (en) begin
        exp_cnt[i] = s[31:0];
        if (s[32]) exp_ovf[i] = 1'b1;
      end
    end
    #1;
    checks++;
    if (perfCounter !== exp_vec() || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL counters: got %h ovf=%b required %h ovf=%b", perfCounter, overflow, exp_vec(), exp_ovf);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40 && !(model_idle && sb.size() == 0); c++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (!(model_idle && sb.size() == 0)) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic step8(input logic en, input logic [13:0] inc, input logic clr);
    en8  = en;
    inc8 = inc;
    clr8 = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    countEnable = 1'b0; eventInc = '0; clearReq = 1'b0; snapshotReq = 1'b0;
    rd_if.rdReady = 1'b0;
    en8 = 1'b0; inc8 = '0; clr8 = 1'b0; snap8 = 1'b0;
    rd8_if.rdReady = 1'b1;
    beats_seen = 0;
    model_reset();
    #23;
    checks++;
    if (perfCounter !== '0 || overflow !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: got %h ovf=%b busy=%b required all 0", perfCounter, overflow, busy);
    end
    checks++;
    if (rd_if.rdValid !== 1'b0 || rd_if.rdLast !== 1'b0 || rd_if.rdIndex !== 3'd0 || rd_if.rdData !== 32'd0) begin
      errors++;
      $display("FAIL reset_readout: valid=%b last=%b idx=%0d data=%h required 0", rd_if.rdValid,
               rd_if.rdLast, rd_if.rdIndex, rd_if.rdData);
    end
    @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic test_count();
    for (int c = 0; c < 10; c++) step(1'b1, inc1(0, 2'd1) | inc1(3, 2'd3), 1'b0, 1'b0, 1'b0);
    checks++;
    if (perfCounter[223 -: 32] !== 32'd10 || perfCounter[96 +: 32] !== 32'd30 || overflow !== 7'd0) begin
      errors++;
      $display("FAIL count_basic: c0=%0d c3=%0d ovf=%b required 10 30 0", perfCounter[223 -: 32],
               perfCounter[96 +: 32], overflow);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 14'h3fff, 1'b0, 1'b0, 1'b0);
    checks++;
    if (perfCounter[223 -: 32] !== 32'd10) begin
      errors++;
      $display("FAIL count_hold: c0=%0d required 10", perfCounter[223 -: 32]);
    end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 84; c++) step8(1'b1, inc1(1, 2'd3), 1'b0);
    step8(1'b1, inc1(1, 2'd2), 1'b0);
    checks++;
    if (perf8[40 +: 8] !== 8'hFE || ovf8 !== 7'd0) begin
      errors++;
      $display("FAIL ovf_preload: got %h ovf=%b required fe 0", perf8[40 +: 8], ovf8);
    end
    step8(1'b1, inc1(1, 2'd3), 1'b0);
    checks++;
    if (perf8[40 +: 8] !== 8'h01 || ovf8 !== 7'b0000010) begin
      errors++;
      $display("FAIL ovf_wrap: got %h ovf=%b required 01 0000010", perf8[40 +: 8], ovf8);
    end
    step8(1'b1, inc1(1, 2'd1), 1'b0);
    checks++;
    if (perf8[40 +: 8] !== 8'h02 || ovf8 !== 7'b0000010) begin
      errors++;
      $display("FAIL ovf_sticky: got %h ovf=%b required 02 0000010", perf8[40 +: 8], ovf8);
    end
    step8(1'b1, inc1(1, 2'd3), 1'b1);
    step8(1'b0, '0, 1'b0);
    checks++;
    if (perf8 !== '0 || ovf8 !== 7'd0) begin
      errors++;
      $display("FAIL ovf_clear: got %h ovf=%b required 0 0", perf8, ovf8);
    end
  endtask

  task automatic test_clear_snapshot();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, inc1(2, 2'd2) | inc1(5, 2'd1), 1'b0, 1'b0, 1'b1);
    step(1'b1, inc1(2, 2'd2), 1'b0, 1'b0, 1'b1);
    step(1'b1, inc1(2, 2'd1), 1'b0, 1'b0, 1'b1);
    step(1'b1, inc1(2, 2'd2), 1'b1, 1'b1, 1'b1);
    checks++;
    if (perfCounter[128 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL clear_wins: c2=%0d required 0", perfCounter[128 +: 32]);
    end
    checks++;
    if (sb.size() != 8 || sb[2].data !== 32'd5) begin
      errors++;
      $display("FAIL snap_model: queued=%0d beat2=%0d required 8 5", sb.size(), sb[2].data);
    end
    drain("clear_snapshot");
  endtask

  task automatic test_stream_full();
    int busy_cycles = 0;
    int start_beats = beats_seen;
    step(1'b1, inc1(4, 2'd3) | inc1(6, 2'd2), 1'b0, 1'b0, 1'b1);
    step(1'b1, inc1(0, 2'd1), 1'b0, 1'b1, 1'b1);
    if (busy === 1'b1) busy_cycles++;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, inc1(1, 2'd1), 1'b0, 1'b0, 1'b1);
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 8 || beats_seen - start_beats != 8) begin
      errors++;
      $display("FAIL stream_full: busy_cycles=%0d beats=%0d required 8 8", busy_cycles, beats_seen - start_beats);
    end
    drain("stream_full");
  endtask

  task automatic test_stall();
    int start_beats = beats_seen;
    step(1'b1, inc1(3, 2'd2), 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 40 && !(model_idle && sb.size() == 0); c++)
      step(1'b1, inc1(c % 7, 2'd3), (c == 7), (c == 5 || c == 9), c[0]);
    checks++;
    if (beats_seen - start_beats != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_beats: beats=%0d pending=%0d required 8 0", beats_seen - start_beats, sb.size());
    end
    for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int c = 0;
    step(1'b1, inc1(5, 2'd1), 1'b0, 1'b1, 1'b1);
    while (rd_if.rdLast !== 1'b1 && c < 20) begin
      step(1'b1, inc1(5, 2'd1), 1'b0, 1'b0, 1'b1);
      c++;
    end
    checks++;
    if (rd_if.rdLast !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last_timeout: rdLast=%b required 1", rd_if.rdLast);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || rd_if.rdValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignored: busy=%b rdValid=%b required 0 0", busy, rd_if.rdValid);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    drain("back_to_back");
  endtask

  task automatic test_reset_midstream();
    int c = 0;
    for (int k = 0; k < 4; k++) step(1'b1, inc1(k, 2'd2), 1'b0, 1'b0, 1'b1);
    step(1'b1, '0, 1'b0, 1'b1, 1'b1);
    while (rd_if.rdIndex !== 3'd3 && c < 20) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      c++;
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (rd_if.rdValid !== 1'b0 || busy !== 1'b0 || perfCounter !== '0 || overflow !== '0) begin
      errors++;
      $display("FAIL reset_midstream: valid=%b busy=%b cnt=%h ovf=%b required all 0",
               rd_if.rdValid, busy, perfCounter, overflow);
    end
    model_reset();
    @(posedge clk);
    #1 rstN = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_clear_snapshot();
    test_stream_full();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
